// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle, then a sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             arith_op, signed_op, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mult_sum, div_shift, div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && arith_op) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand decode and per-step arithmetic
  always_comb begin
    arith_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = signed_op && rs_data[WIDTH-1];
    sign_b    = signed_op && rt_data[WIDTH-1];
    mag_a     = sign_a ? WIDTH'(0) - rs_data : rs_data;
    mag_b     = sign_b ? WIDTH'(0) - rt_data : rt_data;
    mult_sum  = {1'b0, p_hi_q} + {1'b0, (p_lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    prod_fix  = neg_p_q ? W2'(0) - {p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    quo_fix   = dz_q ? {WIDTH{1'b1}} : (neg_p_q ? WIDTH'(0) - p_lo_q : p_lo_q);
    rem_fix   = neg_r_q ? WIDTH'(0) - p_hi_q : p_hi_q;
  end

  // Datapath and output next values
  always_comb begin
    cnt_d    = cnt_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (arith_op) begin
            is_div_d = op[1];
            neg_p_d  = sign_a ^ sign_b;
            neg_r_d  = sign_a;
            dz_d     = op[1] && (rt_data == '0);
            p_hi_d   = '0;
            p_lo_d   = op[1] ? mag_a : mag_b;
            mcand_d  = op[1] ? mag_b : mag_a;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          // Restoring step: keep the difference only when it did not go negative
          if (!div_diff[WIDTH]) p_hi_d = div_diff[WIDTH-1:0];
          else                  p_hi_d = div_shift[WIDTH-1:0];
          p_lo_d = {p_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          p_hi_d = mult_sum[WIDTH:1];
          p_lo_d = {mult_sum[0], p_lo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: driver pushes expected HI/LO from an
// arithmetic reference model, a negedge monitor pops and compares on done.
module tb_hilo_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: returns {hi, lo}
  function automatic logic [63:0] model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a negedge; returns at a negedge with busy low
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    logic [31:0] p_hi, p_lo;
    wait_idle();
    p_hi = m_hi;
    p_lo = m_lo;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    if (o <= 3'd3) begin
      e = model(o, a, b);
      sbq.push_back('{hi: e[63:32], lo: e[31:0], t: cyc});
      m_hi = e[63:32];
      m_lo = e[31:0];
    end else if (o == 3'd4) begin
      m_hi = a;
    end else if (o == 3'd5) begin
      m_lo = a;
    end
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
    if (o <= 3'd3) begin
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("hi_held_in_run", 64'(hi), 64'(p_hi));
      chk("lo_held_in_run", 64'(lo), 64'(p_lo));
    end else begin
      chk("reg_op_hi", 64'(hi), 64'(m_hi));
      chk("reg_op_lo", 64'(lo), 64'(m_lo));
      chk("reg_op_busy", 64'(busy), 64'(0));
      chk("reg_op_done", 64'(done), 64'(0));
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("latency", 64'(cyc - e.t), 64'(34));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [2:0] o;
    rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));

    // Directed corner cases
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, 32'hFFFF_FFF9, 32'd3);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd100, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0);

    // Start while busy is ignored
    issue(3'd3, 32'd50, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation aborts
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    repeat (40) @(negedge clk);

    // Register moves, then back-to-back start on the done cycle
    issue(3'd4, 32'h1234_5678, 32'h0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h0);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("done_on_restart_cycle", 64'(done), 64'(1));
    issue(3'd1, 32'd2, 32'd3);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      o = (r < 8) ? 3'(r % 4) : 3'(4 + $urandom_range(0, 3));
      issue(o, pick_operand(), pick_operand());
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
